// File: rtl/mult_booth_param.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode, start/busy/done
// handshake and abort. Operands are widened by one bit so both modes share one datapath.
module mult_booth_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int XW    = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [XW-1:0]  acc_q, acc_d;
  logic signed [XW-1:0]  m_q, m_d;
  logic signed [XW-1:0]  q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]      lo_q, lo_d;
  logic signed [XW-1:0]  sum;
  logic [2*XW-1:0]       prod;

  // The extra top bit is the sign in MULT mode and zero in MULTU mode.
  function automatic logic signed [XW-1:0] extend(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
    return $signed({sgn & v[WIDTH-1], v});
  endfunction

  function automatic logic signed [XW-1:0] booth_add(input logic signed [XW-1:0] acc,
                                                     input logic signed [XW-1:0] m,
                                                     input logic [1:0] pair);
    case (pair)
      2'b10:   return acc - m;
      2'b01:   return acc + m;
      default: return acc;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sum     = booth_add(acc_q, m_q, {q_q[0], qm1_q});
    prod    = {acc_q, q_q};

    case (state_q)
      IDLE: begin
        // abort takes precedence over a simultaneous start
        if (start && !abort) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          m_d     = extend(op_a, is_signed);
          q_d     = extend(op_b, is_signed);
          qm1_d   = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = {sum[XW-1], sum[XW-1:1]};
          q_d   = {sum[0], q_q[XW-1:1]};
          qm1_d = q_q[0];
          if (cnt_q == LAST_STEP) begin
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!abort) begin
          hi_d   = prod[2*WIDTH-1:WIDTH];
          lo_d   = prod[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_booth_param.sv
// Scoreboard bench for mult_booth_param at WIDTH = 32, 16 and 8, run side by side.
module tb_mult_booth_param;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int w,
                       input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL W=%0d %s: got %0h expected %0h", w, name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int W      = (g == 0) ? 32 : (g == 1) ? 16 : 8;
    localparam int NRND   = (g == 2) ? 100 : 400;
    localparam int ABT_AT = (W >= 16) ? 9 : W / 2;
    localparam int RST_AT = (W >= 24) ? 19 : W / 2;

    logic             rst, start, sgn, abort, busy, done;
    logic [W-1:0]     a, b, hi, lo;
    logic [2*W-1:0]   exp_q[$];
    int               edge_q[$];
    logic [2*W-1:0]   last;
    bit               fin = 1'b0;

    mult_booth_param #(.WIDTH(W)) dut (
      .clk(clk), .reset(rst), .start(start), .is_signed(sgn),
      .op_a(a), .op_b(b), .abort(abort),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Exact product, truncated to 2W bits (the true product always fits).
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic s);
      logic signed [2*W-1:0] ex, ey;
      ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      return ex * ey;
    endfunction

    function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      v = W'($urandom);
      case ($urandom_range(0, 9))
        0: v = '0;
        1: v = '1;
        2: v = {1'b1, {(W-1){1'b0}}};
        3: v = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      return v;
    endfunction

    // Called at posedge+1; start is sampled at the following edge.
    task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; sgn = s; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; sgn = 1'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_q.push_back(ref_mul(x, y, s));
      edge_q.push_back(cyc + 1);
      last = ref_mul(x, y, s);
      launch(s, x, y);
    endtask

    task automatic wait_idle();
      for (int k = 0; k < W + 8 && busy; k++) begin
        @(posedge clk); #1;
      end
      if (busy) check("idle_timeout", W, 128'(busy), '0);
    endtask

    initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; sgn = 1'b0; a = '0; b = '0; last = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", W, 128'(busy), '0);
      check("rst_done", W, 128'(done), '0);
      check("rst_hi", W, 128'(hi), '0);
      check("rst_lo", W, 128'(lo), '0);

      issue(1'b1, W'(7), W'(-3));
      wait_idle();
      // corners, issued back-to-back in each done cycle
      issue(1'b1, '1, '1);
      wait_idle();
      issue(1'b0, '1, '1);
      wait_idle();
      issue(1'b1, {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}});
      wait_idle();
      issue(1'b0, {1'b1, {(W-1){1'b0}}}, W'(2));
      wait_idle();

      // start while busy must be ignored
      issue(1'b1, W'(12345), W'(-77));
      repeat (3) @(posedge clk);
      #1;
      launch(1'b0, '1, '1);
      wait_idle();

      // abort mid-run: no done, hi/lo keep the previous result
      launch(1'b0, rnd_op(), rnd_op());
      repeat (ABT_AT - 1) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", W, 128'(busy), '0);
      repeat (W + 4) @(posedge clk);
      #1;
      check("abort_hilo", W, 128'({hi, lo}), 128'(last));

      // abort with start in IDLE drops the start
      abort = 1'b1;
      launch(1'b1, rnd_op(), rnd_op());
      abort = 1'b0;
      check("abort_start_busy", W, 128'(busy), '0);
      repeat (W + 4) @(posedge clk);
      #1;

      // reset mid-run clears everything
      launch(1'b1, rnd_op(), rnd_op());
      repeat (RST_AT - 1) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", W, 128'(busy), '0);
      check("midrst_done", W, 128'(done), '0);
      check("midrst_hilo", W, 128'({hi, lo}), '0);
      rst = 1'b0;

      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < NRND; i++) begin
          issue(1'(m), rnd_op(), rnd_op());
          wait_idle();
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
      end

      repeat (W + 6) @(posedge clk);
      #1;
      check("queue_empty", W, 128'(exp_q.size()), '0);
      fin = 1'b1;
    end

    always @(negedge clk) begin
      if (done === 1'b1) begin
        check("done_vs_busy", W, 128'(busy), '0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL W=%0d unexpected_done: got hi=%0h lo=%0h expected no done", W, hi, lo);
        end else begin
          logic [2*W-1:0] e;
          int             ed;
          e  = exp_q.pop_front();
          ed = edge_q.pop_front();
          check("product", W, 128'({hi, lo}), 128'(e));
          check("latency", W, 128'(cyc - ed), 128'(W + 2));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 90000 && !(g_w[0].fin && g_w[1].fin && g_w[2].fin); k++)
      @(posedge clk);
    if (!(g_w[0].fin && g_w[1].fin && g_w[2].fin)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL global_timeout: got unfinished stimulus expected all widths finished");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
